// File: rtl/booth_divider.sv
// Sequential signed restoring divider: 2N-bit dividend by N-bit divisor.
// Truncating quotient/remainder with fixed N+2 cycle latency.
module booth_divider #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div_by_zero,
   output logic           overflow
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam int CW = $clog2(N + 1);
   localparam logic [N-1:0] QMAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] QMIN = {1'b1, {(N-1){1'b0}}};

   state_t state, state_nx;

   logic [CW-1:0]  count;
   logic [N-1:0]   dmag, prem, pquo;
   logic           sign_q, sign_r, dz, pre_ovf;
   logic [N-1:0]   q_fix, r_fix;
   logic           dz_fix, ovf_fix;

   logic [2*N-1:0] a_mag;
   logic [N-1:0]   b_mag;
   logic [N:0]     shifted, diff;
   logic           step_ok, q_big;

   always_comb begin
      a_mag   = dividend[2*N-1] ? -dividend : dividend;
      b_mag   = divisor[N-1] ? -divisor : divisor;
      shifted = {prem, pquo[N-1]};
      diff    = shifted - {1'b0, dmag};
      // Borrow out of the N+1-bit subtract means the trial failed.
      step_ok = ~diff[N];
      q_big   = sign_q ? (pquo > QMIN) : (pquo > QMAX);
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = CALC;
         CALC: if (count == CW'(1)) state_nx = FIX;
         FIX:  state_nx = DONE;
         DONE: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         count       <= '0;
         dmag        <= '0;
         prem        <= '0;
         pquo        <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dz          <= 1'b0;
         pre_ovf     <= 1'b0;
         q_fix       <= '0;
         r_fix       <= '0;
         dz_fix      <= 1'b0;
         ovf_fix     <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         unique case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  dmag        <= b_mag;
                  prem        <= a_mag[2*N-1:N];
                  pquo        <= a_mag[N-1:0];
                  sign_q      <= dividend[2*N-1] ^ divisor[N-1];
                  sign_r      <= dividend[2*N-1];
                  dz          <= (b_mag == '0);
                  pre_ovf     <= (a_mag[2*N-1:N] >= b_mag);
                  count       <= CW'(N);
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
            end
            CALC: begin
               busy  <= 1'b1;
               prem  <= step_ok ? diff[N-1:0] : shifted[N-1:0];
               pquo  <= {pquo[N-2:0], step_ok};
               count <= count - CW'(1);
            end
            FIX: begin
               busy    <= 1'b1;
               dz_fix  <= dz;
               ovf_fix <= ~dz & (pre_ovf | q_big);
               q_fix   <= sign_q ? -pquo : pquo;
               r_fix   <= sign_r ? -prem : prem;
            end
            DONE: begin
               busy        <= 1'b0;
               done        <= 1'b1;
               div_by_zero <= dz_fix;
               overflow    <= ovf_fix;
               quotient    <= (dz_fix | ovf_fix) ? '0 : q_fix;
               remainder   <= (dz_fix | ovf_fix) ? '0 : r_fix;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider.sv
// Bench for booth_divider: directed and random operands against an
// integer-arithmetic model of truncating signed division.
module tb_booth_divider;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           busy, done;
   logic [N-1:0]   quotient, remainder;
   logic           div_by_zero, overflow;

   int n_chk  = 0;
   int n_fail = 0;

   booth_divider #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [7:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic dzf, output logic ovf);
      int ai, bi, qi, ri;
      ai = int'($signed(a));
      bi = int'($signed(b));
      q = '0; r = '0; dzf = 1'b0; ovf = 1'b0;
      if (bi == 0) dzf = 1'b1;
      else begin
         qi = ai / bi;
         ri = ai % bi;
         if (qi > 7 || qi < -8) ovf = 1'b1;
         else begin
            q = 4'(qi);
            r = 4'(ri);
         end
      end
   endtask

   task automatic wait_done(output int lat, output int nb, input bit poke);
      lat = -1;
      nb  = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
         end
         if (poke && k == 2) begin
            start    = 1'b1;
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
         end
         if (poke && k == 3) start = 1'b0;
         if (busy) nb++;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic check_res(input string tag, input logic [7:0] a,
                            input logic [3:0] b);
      logic [3:0] eq, er;
      logic edz, eov;
      model(a, b, eq, er, edz, eov);
      chk({tag, ".q"},   int'(quotient),    int'(eq));
      chk({tag, ".r"},   int'(remainder),   int'(er));
      chk({tag, ".dz"},  int'(div_by_zero), int'(edz));
      chk({tag, ".ovf"}, int'(overflow),    int'(eov));
   endtask

   task automatic run_op(input string tag, input logic [7:0] a,
                         input logic [3:0] b, input bit poke);
      int lat, nb;
      logic [3:0] hq;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat, nb, poke);
      chk({tag, ".lat"},  lat, 6);
      chk({tag, ".busy"}, nb, 5);
      check_res(tag, a, b);
      hq = quotient;
      @(posedge clk); #1;
      chk({tag, ".pulse"}, int'(done), 0);
      chk({tag, ".hold"},  int'(quotient), int'(hq));
   endtask

   logic [7:0] da [10] = '{8'd6, 8'hEB, 8'hF9, 8'd7, 8'd5,
                           8'd64, 8'hC0, 8'hC0, 8'hC0, 8'hC8};
   logic [3:0] db [10] = '{4'd2, 4'd3, 4'd2, 4'hE, 4'd0,
                           4'd2, 4'h8, 4'd8, 4'd7, 4'd7};

   initial begin
      int lat, nb, seen;
      rst_n    = 1'b0;
      start    = 1'b1;
      dividend = 8'd6;
      divisor  = 4'd2;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", int'(busy), 0);
      chk("rst.done", int'(done), 0);
      chk("rst.q",    int'(quotient), 0);
      chk("rst.r",    int'(remainder), 0);
      chk("rst.dz",   int'(div_by_zero), 0);
      chk("rst.ovf",  int'(overflow), 0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle.busy", int'(busy), 0);

      for (int i = 0; i < 10; i++)
         run_op($sformatf("dir%0d", i), da[i], db[i], 1'b0);

      run_op("ignore", 8'hEB, 4'd3, 1'b1);

      @(negedge clk);
      dividend = 8'd100;
      divisor  = 4'd7;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst.busy", int'(busy), 0);
      chk("midrst.q",    int'(quotient), 0);
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("midrst.nodone", seen, 0);

      @(negedge clk);
      dividend = 8'hF9;
      divisor  = 4'd2;
      start    = 1'b1;
      @(posedge clk); #1;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
      chk("b2b.lat1", lat, 6);
      check_res("b2b1", 8'hF9, 4'd2);
      dividend = 8'h2D;
      divisor  = 4'hB;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat, nb, 1'b0);
      chk("b2b.lat2", lat, 6);
      check_res("b2b2", 8'h2D, 4'hB);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] a;
         logic [3:0] b;
         b = 4'($urandom);
         a = (i % 2 == 0) ? 8'($urandom)
                          : 8'(int'($urandom_range(0, 60)) - 30);
         run_op($sformatf("rnd%0d", i), a, b, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
